// File: rtl/cache_tag_ctrl_sa_pkg.sv
// Shared constants for the set-associative cache tag controller:
// FSM state encodings and request opcodes.
package cache_pkg;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_LOOKUP    = 3'd1;
  localparam logic [2:0] ST_WB_REQ    = 3'd2;
  localparam logic [2:0] ST_WB_WAIT   = 3'd3;
  localparam logic [2:0] ST_FILL_REQ  = 3'd4;
  localparam logic [2:0] ST_FILL_WAIT = 3'd5;
  localparam logic [2:0] ST_UPDATE    = 3'd6;
  localparam logic [2:0] ST_RESP      = 3'd7;

  localparam logic OP_RD = 1'b0;
  localparam logic OP_WR = 1'b1;

endpackage

// File: rtl/cache_tag_ctrl_sa_lru_set_update.sv
// True-LRU helper for one cache set. Ages are a permutation of
// 0..WAYS-1, age 0 being most recently used. Produces the aged vector
// after touching the target way, and the current LRU victim.
module lru_set_update #(
  parameter int WAYS  = 4,
  parameter int WAY_W = 2
) (
  input  logic [WAYS*WAY_W-1:0] age_i,
  input  logic [WAY_W-1:0]      target_i,
  output logic [WAYS*WAY_W-1:0] age_o,
  output logic [WAY_W-1:0]      victim_o
);

  localparam logic [WAY_W-1:0] OLDEST = WAY_W'(WAYS - 1);

  logic [WAY_W-1:0] target_age;

  // Age every way younger than the target by one, make the target youngest,
  // and pick the way holding the oldest age as the replacement victim.
  always_comb begin
    target_age = '0;
    victim_o   = '0;
    age_o      = age_i;
    for (int w = 0; w < WAYS; w++) begin
      if (WAY_W'(w) == target_i) begin
        target_age = age_i[w*WAY_W +: WAY_W];
      end
      if (age_i[w*WAY_W +: WAY_W] == OLDEST) begin
        victim_o = WAY_W'(w);
      end
    end
    for (int w = 0; w < WAYS; w++) begin
      if (WAY_W'(w) == target_i) begin
        age_o[w*WAY_W +: WAY_W] = '0;
      end else if (age_i[w*WAY_W +: WAY_W] < target_age) begin
        age_o[w*WAY_W +: WAY_W] = age_i[w*WAY_W +: WAY_W] + WAY_W'(1);
      end
    end
  end

endmodule

// File: rtl/cache_tag_ctrl_sa.sv
// Set-associative cache tag controller: tag/valid/dirty/age tracking,
// true-LRU replacement, dirty write-back and a flow-controlled memory port.
module cache_tag_ctrl_sa
  import cache_pkg::*;
#(
  parameter int WAYS   = 4,
  parameter int SETS   = 16,
  parameter int ADDR_W = 12,
  parameter int CNT_W  = 16,
  localparam int WAY_W = $clog2(WAYS),
  localparam int IDX_W = $clog2(SETS),
  localparam int TAG_W = ADDR_W - IDX_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_rw,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              resp_valid,
  output logic              resp_hit,
  output logic [WAY_W-1:0]  resp_way,
  output logic              resp_wb,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_wr,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_done,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt,
  output logic [2:0]        state_out
);

  logic [2:0]        state_q, state_d;
  logic              rw_q, rw_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              hit_q, hit_d;
  logic [WAY_W-1:0]  way_q, way_d;
  logic              wb_q, wb_d;
  logic              mem_req_valid_q, mem_req_valid_d;
  logic              mem_req_wr_q, mem_req_wr_d;
  logic [ADDR_W-1:0] mem_req_addr_q, mem_req_addr_d;
  logic [CNT_W-1:0]  hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0]  miss_cnt_q, miss_cnt_d;

  logic [TAG_W-1:0]      tag_q [SETS][WAYS];
  logic [TAG_W-1:0]      tag_d [SETS][WAYS];
  logic [WAYS-1:0]       valid_q [SETS];
  logic [WAYS-1:0]       valid_d [SETS];
  logic [WAYS-1:0]       dirty_q [SETS];
  logic [WAYS-1:0]       dirty_d [SETS];
  logic [WAYS*WAY_W-1:0] age_q [SETS];
  logic [WAYS*WAY_W-1:0] age_d [SETS];

  logic [IDX_W-1:0]      idx;
  logic [TAG_W-1:0]      tag;
  logic                  hit_any;
  logic [WAY_W-1:0]      hit_way;
  logic                  inv_any;
  logic [WAY_W-1:0]      inv_way;
  logic [WAY_W-1:0]      lru_victim;
  logic [WAY_W-1:0]      victim;
  logic [WAYS*WAY_W-1:0] new_age;

  assign idx = addr_q[IDX_W-1:0];
  assign tag = addr_q[ADDR_W-1:IDX_W];

  lru_set_update #(
    .WAYS  (WAYS),
    .WAY_W (WAY_W)
  ) u_lru (
    .age_i    (age_q[idx]),
    .target_i (way_q),
    .age_o    (new_age),
    .victim_o (lru_victim)
  );

  // Tag match across the indexed set and the lowest-numbered empty way.
  always_comb begin
    hit_any = 1'b0;
    hit_way = '0;
    inv_any = 1'b0;
    inv_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[idx][w] && (tag_q[idx][w] == tag)) begin
        hit_any = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[idx][w]) begin
        inv_any = 1'b1;
        inv_way = WAY_W'(w);
      end
    end
  end

  assign victim = inv_any ? inv_way : lru_victim;

  // Next-state logic: request sequencing, memory handshake and tag-state update.
  always_comb begin
    state_d         = state_q;
    rw_d            = rw_q;
    addr_d          = addr_q;
    hit_d           = hit_q;
    way_d           = way_q;
    wb_d            = wb_q;
    mem_req_valid_d = mem_req_valid_q;
    mem_req_wr_d    = mem_req_wr_q;
    mem_req_addr_d  = mem_req_addr_q;
    hit_cnt_d       = hit_cnt_q;
    miss_cnt_d      = miss_cnt_q;
    tag_d           = tag_q;
    valid_d         = valid_q;
    dirty_d         = dirty_q;
    age_d           = age_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          rw_d    = req_rw;
          addr_d  = req_addr;
          state_d = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        if (hit_any) begin
          hit_d   = 1'b1;
          way_d   = hit_way;
          wb_d    = 1'b0;
          state_d = ST_UPDATE;
        end else begin
          hit_d           = 1'b0;
          way_d           = victim;
          mem_req_valid_d = 1'b1;
          if (valid_q[idx][victim] && dirty_q[idx][victim]) begin
            wb_d           = 1'b1;
            mem_req_wr_d   = 1'b1;
            mem_req_addr_d = {tag_q[idx][victim], idx};
            state_d        = ST_WB_REQ;
          end else begin
            wb_d           = 1'b0;
            mem_req_wr_d   = 1'b0;
            mem_req_addr_d = addr_q;
            state_d        = ST_FILL_REQ;
          end
        end
      end
      ST_WB_REQ: begin
        if (mem_req_ready) begin
          mem_req_valid_d = 1'b0;
          state_d         = ST_WB_WAIT;
        end
      end
      ST_WB_WAIT: begin
        if (mem_done) begin
          mem_req_valid_d = 1'b1;
          mem_req_wr_d    = 1'b0;
          mem_req_addr_d  = addr_q;
          state_d         = ST_FILL_REQ;
        end
      end
      ST_FILL_REQ: begin
        if (mem_req_ready) begin
          mem_req_valid_d = 1'b0;
          state_d         = ST_FILL_WAIT;
        end
      end
      ST_FILL_WAIT: begin
        if (mem_done) begin
          state_d = ST_UPDATE;
        end
      end
      ST_UPDATE: begin
        valid_d[idx][way_q] = 1'b1;
        tag_d[idx][way_q]   = tag;
        dirty_d[idx][way_q] = hit_q ? (dirty_q[idx][way_q] | rw_q) : rw_q;
        age_d[idx]          = new_age;
        if (hit_q) begin
          if (hit_cnt_q != '1) begin
            hit_cnt_d = hit_cnt_q + CNT_W'(1);
          end
        end else begin
          if (miss_cnt_q != '1) begin
            miss_cnt_d = miss_cnt_q + CNT_W'(1);
          end
        end
        state_d = ST_RESP;
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers with asynchronous reset; ages restart as the identity permutation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      rw_q            <= OP_RD;
      addr_q          <= '0;
      hit_q           <= 1'b0;
      way_q           <= '0;
      wb_q            <= 1'b0;
      mem_req_valid_q <= 1'b0;
      mem_req_wr_q    <= 1'b0;
      mem_req_addr_q  <= '0;
      hit_cnt_q       <= '0;
      miss_cnt_q      <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        for (int w = 0; w < WAYS; w++) begin
          tag_q[s][w]               <= '0;
          age_q[s][w*WAY_W +: WAY_W] <= WAY_W'(w);
        end
      end
    end else begin
      state_q         <= state_d;
      rw_q            <= rw_d;
      addr_q          <= addr_d;
      hit_q           <= hit_d;
      way_q           <= way_d;
      wb_q            <= wb_d;
      mem_req_valid_q <= mem_req_valid_d;
      mem_req_wr_q    <= mem_req_wr_d;
      mem_req_addr_q  <= mem_req_addr_d;
      hit_cnt_q       <= hit_cnt_d;
      miss_cnt_q      <= miss_cnt_d;
      tag_q           <= tag_d;
      valid_q         <= valid_d;
      dirty_q         <= dirty_d;
      age_q           <= age_d;
    end
  end

  assign req_ready     = (state_q == ST_IDLE);
  assign resp_valid    = (state_q == ST_RESP);
  assign resp_hit      = resp_valid & hit_q;
  assign resp_way      = resp_valid ? way_q : '0;
  assign resp_wb       = resp_valid & wb_q;
  assign mem_req_valid = mem_req_valid_q;
  assign mem_req_wr    = mem_req_wr_q;
  assign mem_req_addr  = mem_req_addr_q;
  assign hit_cnt       = hit_cnt_q;
  assign miss_cnt      = miss_cnt_q;
  assign state_out     = state_q;

endmodule

// File: tb/tb_cache_tag_ctrl_sa.sv
// Directed testbench for cache_tag_ctrl_sa (4 ways, 4 sets, 8-bit addresses).
// The bench plays the memory: it accepts each request one cycle after seeing
// it and pulses mem_done two cycles later.
module tb_cache_tag_ctrl_sa;

  localparam int WAYS   = 4;
  localparam int SETS   = 4;
  localparam int ADDR_W = 8;
  localparam int CNT_W  = 16;

  logic              clk;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic              req_rw;
  logic [ADDR_W-1:0] req_addr;
  logic              resp_valid;
  logic              resp_hit;
  logic [1:0]        resp_way;
  logic              resp_wb;
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic              mem_req_wr;
  logic [ADDR_W-1:0] mem_req_addr;
  logic              mem_done;
  logic [CNT_W-1:0]  hit_cnt;
  logic [CNT_W-1:0]  miss_cnt;
  logic [2:0]        state_out;

  int compared   = 0;
  int mismatched = 0;
  int exp_hit    = 0;
  int exp_miss   = 0;

  cache_tag_ctrl_sa #(
    .WAYS   (WAYS),
    .SETS   (SETS),
    .ADDR_W (ADDR_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_rw        (req_rw),
    .req_addr      (req_addr),
    .resp_valid    (resp_valid),
    .resp_hit      (resp_hit),
    .resp_way      (resp_way),
    .resp_wb       (resp_wb),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_wr    (mem_req_wr),
    .mem_req_addr  (mem_req_addr),
    .mem_done      (mem_done),
    .hit_cnt       (hit_cnt),
    .miss_cnt      (miss_cnt),
    .state_out     (state_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit         do_reset;
    bit         rw;
    logic [7:0] addr;
    bit         hit;
    logic [1:0] way;
    bit         wb;
    logic [7:0] wb_addr;
  } vec_t;

  vec_t vecs [$];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_hit  = 0;
    exp_miss = 0;
  endtask

  task automatic waitState(input logic [2:0] s, input string name);
    for (int c = 0; c < 20; c++) begin
      if (state_out == s) break;
      @(negedge clk);
    end
    checkOutput(name, {29'd0, state_out}, {29'd0, s});
  endtask

  task automatic applyStimulus(input logic rw, input logic [7:0] addr,
                               output bit got_resp, output logic hit,
                               output logic [1:0] way, output logic wb,
                               output bit wb_seen, output logic [7:0] wb_addr,
                               output bit fill_seen, output logic [7:0] fill_addr,
                               output int cycles);
    got_resp  = 0;
    hit       = 0;
    way       = '0;
    wb        = 0;
    wb_seen   = 0;
    wb_addr   = '0;
    fill_seen = 0;
    fill_addr = '0;
    cycles    = 0;
    @(negedge clk);
    checkOutput("req_ready before accept", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_rw    = rw;
    req_addr  = addr;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_rw    = 1'b0;
    req_addr  = '0;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (resp_valid) begin
        got_resp = 1;
        hit      = resp_hit;
        way      = resp_way;
        wb       = resp_wb;
        cycles   = c;
        break;
      end
      if (mem_req_valid) begin
        if (mem_req_wr) begin
          wb_seen = 1;
          wb_addr = mem_req_addr;
        end else begin
          fill_seen = 1;
          fill_addr = mem_req_addr;
        end
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        @(negedge clk);
        mem_done = 1'b1;
        @(negedge clk);
        mem_done = 1'b0;
      end
    end
    if (!got_resp) begin
      checkOutput("response timeout", 32'd0, 32'd1);
    end
  endtask

  initial begin
    bit         got_resp;
    logic       hit;
    logic [1:0] way;
    logic       wb;
    bit         wb_seen;
    logic [7:0] wb_addr;
    bit         fill_seen;
    logic [7:0] fill_addr;
    int         cycles;

    rst           = 1'b1;
    req_valid     = 1'b0;
    req_rw        = 1'b0;
    req_addr      = '0;
    mem_req_ready = 1'b0;
    mem_done      = 1'b0;

    // Scenario A: cold miss then hit on 0x10
    vecs.push_back('{1, 0, 8'h10, 0, 2'd0, 0, 8'h00});
    vecs.push_back('{0, 0, 8'h10, 1, 2'd0, 0, 8'h00});
    // Scenario B: fill set 0 with dirty lines, then evict dirty 0x00
    vecs.push_back('{1, 1, 8'h00, 0, 2'd0, 0, 8'h00});
    vecs.push_back('{0, 1, 8'h04, 0, 2'd1, 0, 8'h00});
    vecs.push_back('{0, 1, 8'h08, 0, 2'd2, 0, 8'h00});
    vecs.push_back('{0, 1, 8'h0C, 0, 2'd3, 0, 8'h00});
    vecs.push_back('{0, 0, 8'h10, 0, 2'd0, 1, 8'h00});
    vecs.push_back('{0, 0, 8'h04, 1, 2'd1, 0, 8'h00});
    // Scenario C: LRU ordering, clean evictions, later dirty eviction of 0x04
    vecs.push_back('{1, 0, 8'h00, 0, 2'd0, 0, 8'h00});
    vecs.push_back('{0, 0, 8'h04, 0, 2'd1, 0, 8'h00});
    vecs.push_back('{0, 0, 8'h08, 0, 2'd2, 0, 8'h00});
    vecs.push_back('{0, 0, 8'h0C, 0, 2'd3, 0, 8'h00});
    vecs.push_back('{0, 0, 8'h00, 1, 2'd0, 0, 8'h00});
    vecs.push_back('{0, 0, 8'h10, 0, 2'd1, 0, 8'h00});
    vecs.push_back('{0, 1, 8'h04, 0, 2'd2, 0, 8'h00});
    vecs.push_back('{0, 0, 8'h14, 0, 2'd3, 0, 8'h00});
    vecs.push_back('{0, 0, 8'h18, 0, 2'd0, 0, 8'h00});
    vecs.push_back('{0, 0, 8'h1C, 0, 2'd1, 0, 8'h00});
    vecs.push_back('{0, 0, 8'h30, 0, 2'd2, 1, 8'h04});
    vecs.push_back('{0, 0, 8'h21, 0, 2'd0, 0, 8'h00});

    repeat (2) @(negedge clk);
    checkOutput("reset state_out", {29'd0, state_out}, 32'd0);
    checkOutput("reset req_ready", {31'd0, req_ready}, 32'd1);
    checkOutput("reset resp_valid", {31'd0, resp_valid}, 32'd0);
    checkOutput("reset mem_req_valid", {31'd0, mem_req_valid}, 32'd0);
    checkOutput("reset counters", {hit_cnt, miss_cnt}, 32'd0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      if (vecs[i].do_reset) doReset();
      applyStimulus(vecs[i].rw, vecs[i].addr, got_resp, hit, way, wb,
                    wb_seen, wb_addr, fill_seen, fill_addr, cycles);
      if (vecs[i].hit) exp_hit++;
      else exp_miss++;
      checkOutput($sformatf("vec%0d resp_hit", i), {31'd0, hit}, {31'd0, vecs[i].hit});
      checkOutput($sformatf("vec%0d resp_way", i), {30'd0, way}, {30'd0, vecs[i].way});
      checkOutput($sformatf("vec%0d resp_wb", i), {31'd0, wb}, {31'd0, vecs[i].wb});
      checkOutput($sformatf("vec%0d writeback issued", i), {31'd0, wb_seen}, {31'd0, vecs[i].wb});
      checkOutput($sformatf("vec%0d fill issued", i), {31'd0, fill_seen}, {31'd0, !vecs[i].hit});
      if (vecs[i].wb) begin
        checkOutput($sformatf("vec%0d writeback addr", i), {24'd0, wb_addr}, {24'd0, vecs[i].wb_addr});
      end
      if (!vecs[i].hit) begin
        checkOutput($sformatf("vec%0d fill addr", i), {24'd0, fill_addr}, {24'd0, vecs[i].addr});
      end else begin
        checkOutput($sformatf("vec%0d hit latency", i), cycles, 32'd3);
      end
      checkOutput($sformatf("vec%0d hit_cnt", i), {16'd0, hit_cnt}, exp_hit);
      checkOutput($sformatf("vec%0d miss_cnt", i), {16'd0, miss_cnt}, exp_miss);
    end

    // Stall in FILL_REQ with a stray mem_done, then done coincident with ready
    doReset();
    @(negedge clk);
    req_valid = 1'b1;
    req_rw    = 1'b0;
    req_addr  = 8'h10;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_addr  = '0;
    @(negedge clk);
    waitState(3'd4, "reach FILL_REQ");
    for (int c = 0; c < 5; c++) begin
      mem_done = (c == 1);
      checkOutput($sformatf("stall%0d mem_req_valid", c), {31'd0, mem_req_valid}, 32'd1);
      checkOutput($sformatf("stall%0d mem_req_addr", c), {24'd0, mem_req_addr}, 32'h10);
      checkOutput($sformatf("stall%0d mem_req_wr", c), {31'd0, mem_req_wr}, 32'd0);
      checkOutput($sformatf("stall%0d req_ready", c), {31'd0, req_ready}, 32'd0);
      @(negedge clk);
    end
    mem_done = 1'b0;
    checkOutput("stall state held", {29'd0, state_out}, 32'd4);
    mem_req_ready = 1'b1;
    mem_done      = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    mem_done      = 1'b0;
    checkOutput("accepted mem_req_valid", {31'd0, mem_req_valid}, 32'd0);
    @(negedge clk);
    checkOutput("coincident done ignored", {29'd0, state_out}, 32'd5);
    mem_done = 1'b1;
    @(negedge clk);
    mem_done = 1'b0;
    @(negedge clk);
    checkOutput("stall resp_valid", {31'd0, resp_valid}, 32'd1);
    checkOutput("stall resp_hit", {31'd0, resp_hit}, 32'd0);
    checkOutput("stall resp_way", {30'd0, resp_way}, 32'd0);
    checkOutput("stall miss_cnt", {16'd0, miss_cnt}, 32'd1);

    // Reset while waiting for a fill, then same address must miss again
    @(negedge clk);
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = 8'h24;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_addr  = '0;
    @(negedge clk);
    waitState(3'd4, "reach FILL_REQ again");
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    checkOutput("in FILL_WAIT", {29'd0, state_out}, 32'd5);
    rst = 1'b1;
    #1;
    checkOutput("mid reset state_out", {29'd0, state_out}, 32'd0);
    checkOutput("mid reset req_ready", {31'd0, req_ready}, 32'd1);
    checkOutput("mid reset mem_req_valid", {31'd0, mem_req_valid}, 32'd0);
    checkOutput("mid reset mem_req_addr", {24'd0, mem_req_addr}, 32'd0);
    checkOutput("mid reset counters", {hit_cnt, miss_cnt}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1'b0, 8'h24, got_resp, hit, way, wb, wb_seen, wb_addr, fill_seen, fill_addr, cycles);
    checkOutput("post reset 0x24 hit", {31'd0, hit}, 32'd0);
    checkOutput("post reset 0x24 way", {30'd0, way}, 32'd0);
    checkOutput("post reset miss_cnt", {16'd0, miss_cnt}, 32'd1);
    applyStimulus(1'b0, 8'h10, got_resp, hit, way, wb, wb_seen, wb_addr, fill_seen, fill_addr, cycles);
    checkOutput("post reset 0x10 hit", {31'd0, hit}, 32'd0);
    checkOutput("post reset 0x10 way", {30'd0, way}, 32'd1);
    checkOutput("post reset counters", {hit_cnt, miss_cnt}, {16'd0, 16'd2});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
